// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned DEFAULT_XLEN = 32;
    localparam int unsigned DEFAULT_OPW  = 16;

    localparam int unsigned OP_MUL_BIT = 10;
    localparam int unsigned OP_DIV_BIT = 11;
    localparam int unsigned OP_REM_BIT = 12;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    typedef enum logic [1:0] {OpMul, OpDiv, OpRem, OpIll} op_e;

endpackage

// File: rtl/muldiv_if.sv
// Operand/op request and result handshake between the execute stage and muldiv_seq.
interface muldiv_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned OPW  = 16
);

    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in1;
    logic [XLEN-1:0]   in2;
    logic [OPW-1:0]    instructions;
    logic              out_valid;
    logic              out_ready;
    logic [2*XLEN-1:0] result;
    logic              out_illegal;
    logic              busy;

    modport master (
        output in_valid, in1, in2, instructions, out_ready,
        input  in_ready, out_valid, result, out_illegal, busy
    );

    modport slave (
        input  in_valid, in1, in2, instructions, out_ready,
        output in_ready, out_valid, result, out_illegal, busy
    );

endinterface

// File: rtl/muldiv_signfix.sv
// Two-lane conditional two's-complement negation: independent lanes give operand magnitudes,
// chained lanes negate a double-width value, optionally sign-extending the low lane.
module muldiv_signfix #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0]   hi_i,
    input  logic [XLEN-1:0]   lo_i,
    input  logic              neg_hi_i,
    input  logic              neg_lo_i,
    input  logic              wide_i,
    input  logic              sext_i,
    output logic [2*XLEN-1:0] res_o
);

    logic [XLEN-1:0] lo_fix;
    logic [XLEN-1:0] hi_fix;
    logic            hi_inc;

    always_comb begin
        lo_fix = neg_lo_i ? (~lo_i + XLEN'(1)) : lo_i;
        // When chained, the +1 only ripples into the high lane if the low lane was zero.
        hi_inc = wide_i ? (lo_i == '0) : 1'b1;
        hi_fix = neg_hi_i ? (~hi_i + {{(XLEN-1){1'b0}}, hi_inc}) : hi_i;
        res_o  = sext_i ? {{XLEN{lo_fix[XLEN-1]}}, lo_fix} : {hi_fix, lo_fix};
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative signed MUL/DIV/REM unit, one bit per cycle, valid/ready on both sides.
// Optional MULDIV_EARLY_OUT_EN: trivial cases (div by zero, overflow, MUL by zero) skip CALC.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = DEFAULT_XLEN,
    parameter int unsigned OPW  = DEFAULT_OPW
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);

    localparam int unsigned    CntW    = $clog2(XLEN);
    localparam logic [OPW-1:0] MulCode = OPW'(1) << OP_MUL_BIT;
    localparam logic [OPW-1:0] DivCode = OPW'(1) << OP_DIV_BIT;
    localparam logic [OPW-1:0] RemCode = OPW'(1) << OP_REM_BIT;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    op_e               op_q, op_d;
    logic [2*XLEN-1:0] work_q, work_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic              neg_q, neg_d;
    logic              div0_q, div0_d;
    logic [2*XLEN-1:0] result_q, result_d;
    logic              illegal_q, illegal_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;

    op_e               op_in;
    logic              in_div0;
    logic [2*XLEN-1:0] mags;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] work_step;
    logic [2*XLEN-1:0] fix_raw;
    logic              fix_sext;
    logic [2*XLEN-1:0] fixed;

    muldiv_signfix #(.XLEN(XLEN)) u_fix_in (
        .hi_i     (bus.in1),
        .lo_i     (bus.in2),
        .neg_hi_i (bus.in1[XLEN-1]),
        .neg_lo_i (bus.in2[XLEN-1]),
        .wide_i   (1'b0),
        .sext_i   (1'b0),
        .res_o    (mags)
    );

    assign mag_a   = mags[2*XLEN-1:XLEN];
    assign mag_b   = mags[XLEN-1:0];
    assign in_div0 = (bus.in2 == '0);

    always_comb begin
        op_in = OpIll;
        if (bus.instructions == MulCode) begin
            op_in = OpMul;
        end else if (bus.instructions == DivCode) begin
            op_in = OpDiv;
        end else if (bus.instructions == RemCode) begin
            op_in = OpRem;
        end
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic              in_ovf;
    logic              early_hit;
    logic [2*XLEN-1:0] early_val;
    logic [2*XLEN-1:0] in1_sext;

    assign in_ovf   = (bus.in1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.in2 == '1);
    assign in1_sext = {{XLEN{bus.in1[XLEN-1]}}, bus.in1};

    always_comb begin
        early_hit = 1'b0;
        early_val = '0;
        if (op_in == OpMul) begin
            early_hit = (bus.in1 == '0) || in_div0;
        end else if (op_in == OpDiv) begin
            early_hit = in_div0 || in_ovf;
            early_val = in_div0 ? '1 : in1_sext;
        end else if (op_in == OpRem) begin
            early_hit = in_div0 || in_ovf;
            early_val = in_div0 ? in1_sext : '0;
        end
    end
`endif

    // One iteration: shift-add for MUL (multiplier in low half), restoring step for DIV/REM
    // (remainder in high half, quotient shifting into low half).
    always_comb begin
        mul_sum   = {1'b0, work_q[2*XLEN-1:XLEN]} + (work_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {work_q[2*XLEN-1:XLEN], work_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        if (op_q == OpMul) begin
            work_step = {mul_sum, work_q[XLEN-1:1]};
        end else if (!div_diff[XLEN]) begin
            work_step = {div_diff[XLEN-1:0], work_q[XLEN-2:0], 1'b1};
        end else begin
            work_step = {div_shift[XLEN-1:0], work_q[XLEN-2:0], 1'b0};
        end
    end

    always_comb begin
        fix_raw  = work_step;
        fix_sext = 1'b0;
        if (op_q == OpDiv) begin
            fix_raw  = {{XLEN{1'b0}}, work_step[XLEN-1:0]};
            fix_sext = 1'b1;
        end else if (op_q == OpRem) begin
            fix_raw  = {{XLEN{1'b0}}, work_step[2*XLEN-1:XLEN]};
            fix_sext = 1'b1;
        end
    end

    muldiv_signfix #(.XLEN(XLEN)) u_fix_out (
        .hi_i     (fix_raw[2*XLEN-1:XLEN]),
        .lo_i     (fix_raw[XLEN-1:0]),
        .neg_hi_i (neg_q),
        .neg_lo_i (neg_q),
        .wide_i   (1'b1),
        .sext_i   (fix_sext),
        .res_o    (fixed)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        work_d    = work_q;
        opb_d     = opb_q;
        neg_d     = neg_q;
        div0_d    = div0_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    op_d      = op_in;
                    div0_d    = in_div0;
                    cnt_d     = '0;
                    illegal_d = (op_in == OpIll);
                    // Remainder follows the dividend; product and quotient follow the sign XOR.
                    neg_d     = (op_in == OpRem) ? bus.in1[XLEN-1]
                                                 : bus.in1[XLEN-1] ^ bus.in2[XLEN-1];
                    if (op_in == OpMul) begin
                        opb_d  = mag_a;
                        work_d = {{XLEN{1'b0}}, mag_b};
                    end else begin
                        opb_d  = mag_b;
                        work_d = {{XLEN{1'b0}}, mag_a};
                    end
                    if (op_in == OpIll) begin
                        state_d  = StDone;
                        result_d = '0;
                    end
`ifdef MULDIV_EARLY_OUT_EN
                    else if (early_hit) begin
                        state_d  = StDone;
                        result_d = early_val;
                    end
`endif
                    else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                work_d = work_step;
                cnt_d  = cnt_q + CntW'(1);
                if (cnt_q == CntW'(XLEN - 1)) begin
                    state_d  = StDone;
                    cnt_d    = '0;
                    // Restoring division by zero yields all-ones magnitude; force the defined value.
                    result_d = (div0_q && (op_q == OpDiv)) ? '1 : fixed;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        in_ready_d  = (state_d == StIdle);
        out_valid_d = (state_d == StDone);
        busy_d      = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            op_q        <= OpMul;
            work_q      <= '0;
            opb_q       <= '0;
            neg_q       <= 1'b0;
            div0_q      <= 1'b0;
            result_q    <= '0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            work_q      <= work_d;
            opb_q       <= opb_d;
            neg_q       <= neg_d;
            div0_q      <= div0_d;
            result_q    <= result_d;
            illegal_q   <= illegal_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.result      = result_q;
    assign bus.out_illegal = illegal_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed plus randomized bench for muldiv_seq against an arithmetic reference model.
module tb_muldiv_seq;

    localparam int unsigned XLEN = 32;
    localparam int unsigned OPW  = 16;
    localparam logic [15:0] OP_MUL = 16'd1024;
    localparam logic [15:0] OP_DIV = 16'd2048;
    localparam logic [15:0] OP_REM = 16'd4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    muldiv_if #(.XLEN(XLEN), .OPW(OPW)) bus ();

    muldiv_seq #(.XLEN(XLEN), .OPW(OPW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Plain signed arithmetic; latency from the op class and build option.
    task automatic ref_model(input logic [15:0] op, input logic [31:0] a, input logic [31:0] b,
                             output logic [63:0] res, output logic ill, output int lat);
        longint sa, sb;
        logic   div0, ovf;
        sa   = longint'(signed'(a));
        sb   = longint'(signed'(b));
        div0 = (b == 32'd0);
        ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        ill  = 1'b0;
        lat  = 33;
        res  = '0;
        if (op == OP_MUL) begin
            res = sa * sb;
`ifdef MULDIV_EARLY_OUT_EN
            if (a == 32'd0 || b == 32'd0) lat = 1;
`endif
        end else if (op == OP_DIV) begin
            if (div0) res = '1;
            else if (ovf) res = sa;
            else res = sa / sb;
`ifdef MULDIV_EARLY_OUT_EN
            if (div0 || ovf) lat = 1;
`endif
        end else if (op == OP_REM) begin
            if (div0) res = sa;
            else if (ovf) res = '0;
            else res = sa % sb;
`ifdef MULDIV_EARLY_OUT_EN
            if (div0 || ovf) lat = 1;
`endif
        end else begin
            ill = 1'b1;
            lat = 1;
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        logic [63:0] er;
        logic        eill;
        int          elat;
        int          lat;
        ref_model(op, a, b, er, eill, elat);
        @(negedge clk);
        bus.in_valid     = 1'b1;
        bus.in1          = a;
        bus.in2          = b;
        bus.instructions = op;
        chk({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            lat++;
        end while (!bus.out_valid && lat < 100);
        chk({tag, "_lat"}, 64'(lat), 64'(elat));
        chk({tag, "_res"}, bus.result, er);
        chk({tag, "_ill"}, 64'(bus.out_illegal), 64'(eill));
        chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
        @(posedge clk);
        #1;
        chk({tag, "_drop"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_idle"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        logic [15:0] rop;
        logic [31:0] ra, rb;

        bus.in_valid     = 1'b0;
        bus.in1          = '0;
        bus.in2          = '0;
        bus.instructions = '0;
        bus.out_ready    = 1'b1;
        rst              = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_result", bus.result, 64'd0);
        chk("rst_illegal", 64'(bus.out_illegal), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("mul_neg", OP_MUL, -32'sd5, 32'sd4);
        chk("mul_neg_const", bus.result, 64'hFFFF_FFFF_FFFF_FFEC);
        run_op("div_neg", OP_DIV, -32'sd7, 32'sd2);
        chk("div_neg_const", bus.result, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("rem_neg", OP_REM, -32'sd7, 32'sd2);
        chk("rem_neg_const", bus.result, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("div_zero", OP_DIV, 32'd10, 32'd0);
        run_op("rem_zero", OP_REM, 32'd10, 32'd0);
        chk("rem_zero_const", bus.result, 64'h0000_0000_0000_000A);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_const", bus.result, 64'hFFFF_FFFF_8000_0000);
        run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("mul_zero", OP_MUL, 32'd0, 32'h1234_5678);
        run_op("mul_min", OP_MUL, 32'h8000_0000, 32'h8000_0000);
        run_op("ill_multi", OP_MUL | OP_DIV, 32'd3, 32'd4);

        // Illegal op with the consumer stalled: result held, new requests ignored.
        @(negedge clk);
        bus.out_ready    = 1'b0;
        bus.in_valid     = 1'b1;
        bus.instructions = 16'd2;
        bus.in1          = 32'd9;
        bus.in2          = 32'd9;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("stall_valid0", 64'(bus.out_valid), 64'd1);
        chk("stall_ill0", 64'(bus.out_illegal), 64'd1);
        chk("stall_res0", bus.result, 64'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.in_valid     = 1'b1;
            bus.instructions = OP_MUL;
            bus.in1          = 32'd3;
            bus.in2          = 32'd3;
            @(posedge clk);
            #1;
            chk("stall_valid", 64'(bus.out_valid), 64'd1);
            chk("stall_res", bus.result, 64'd0);
            chk("stall_ready", 64'(bus.in_ready), 64'd0);
            chk("stall_ill", 64'(bus.out_illegal), 64'd1);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_release_valid", 64'(bus.out_valid), 64'd0);
        chk("stall_release_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        chk("stall_no_accept", 64'(bus.busy), 64'd0);

        // Reset ten cycles into a DIV.
        @(negedge clk);
        bus.in_valid     = 1'b1;
        bus.instructions = OP_DIV;
        bus.in1          = 32'd1000;
        bus.in2          = 32'd7;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("mid_busy", 64'(bus.busy), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_ready", 64'(bus.in_ready), 64'd1);
        chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_result", bus.result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("post_rst", OP_DIV, 32'd1000, 32'd7);

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 7))
                0, 1, 2: rop = OP_MUL;
                3, 4:    rop = OP_DIV;
                5, 6:    rop = OP_REM;
                default: rop = 16'($urandom);
            endcase
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(0, 15)) - 32'd8;
                2: ra = 32'($urandom_range(0, 255)) - 32'd128;
                default: ;
            endcase
            run_op($sformatf("rnd%0d", i), rop, ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
